// File: rtl/call_stack_lifo.sv
`default_nettype none
// ============================================================================
// Module      : call_stack_lifo
// Description : Register-array LIFO with combinational top-of-stack read,
//               saturating pointer and sticky overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module call_stack_lifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int PTR_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pushEn,
    input  logic             popEn,
    input  logic             clear,
    input  logic [WIDTH-1:0] dataIn,
    output logic [WIDTH-1:0] stackOut,
    output logic             stackFull,
    output logic             stackEmpty,
    output logic [PTR_W-1:0] count,
    output logic             overflow,
    output logic             underflow
);

    localparam int               c_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] c_DEPTH_PTR = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] c_ONE       = PTR_W'(1);

    logic [WIDTH-1:0]   r_mem [0:DEPTH-1];
    logic [PTR_W-1:0]   r_sp;
    logic               r_overflow;
    logic               r_underflow;

    logic               w_full;
    logic               w_empty;
    logic [c_IDX_W-1:0] w_top_idx;
    logic [c_IDX_W-1:0] w_wr_idx;
    logic               w_wr_en;
    logic [PTR_W-1:0]   w_sp_next;

    assign w_full    = (r_sp == c_DEPTH_PTR);
    assign w_empty   = (r_sp == '0);
    assign w_top_idx = c_IDX_W'(r_sp - c_ONE);

    // Simultaneous push+pop on a non-empty stack overwrites the top in place;
    // on an empty stack it degenerates to a plain push into entry 0.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_idx  = c_IDX_W'(r_sp);
        w_sp_next = r_sp;
        if (!reset && !clear) begin
            if (pushEn && popEn) begin
                w_wr_en = 1'b1;
                if (w_empty) begin
                    w_sp_next = c_ONE;
                end else begin
                    w_wr_idx = w_top_idx;
                end
            end else if (pushEn) begin
                if (!w_full) begin
                    w_wr_en   = 1'b1;
                    w_sp_next = r_sp + c_ONE;
                end
            end else if (popEn) begin
                if (!w_empty) begin
                    w_sp_next = r_sp - c_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sp        <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clear) begin
            r_sp        <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_sp <= w_sp_next;
            if (pushEn && !popEn && w_full) begin
                r_overflow <= 1'b1;
            end
            if (popEn && !pushEn && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset; only entries below sp are visible.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= dataIn;
        end
    end

    assign stackOut   = w_empty ? '0 : r_mem[w_top_idx];
    assign stackFull  = w_full;
    assign stackEmpty = w_empty;
    assign count      = r_sp;
    assign overflow   = r_overflow;
    assign underflow  = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_call_stack_lifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_call_stack_lifo
// Description : Queue-based reference model with per-cycle output comparison,
//               directed scenarios and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_call_stack_lifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int PTR_W = 5;

    logic             clk;
    logic             reset;
    logic             pushEn;
    logic             popEn;
    logic             clear;
    logic [WIDTH-1:0] dataIn;
    logic [WIDTH-1:0] stackOut;
    logic             stackFull;
    logic             stackEmpty;
    logic [PTR_W-1:0] count;
    logic             overflow;
    logic             underflow;

    int n_cmp;
    int n_bad;
    bit chk_en;

    logic [WIDTH-1:0] m_stk [$];
    bit               m_ovf;
    bit               m_unf;

    call_stack_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .pushEn     (pushEn),
        .popEn      (popEn),
        .clear      (clear),
        .dataIn     (dataIn),
        .stackOut   (stackOut),
        .stackFull  (stackFull),
        .stackEmpty (stackEmpty),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] m_top();
        return (m_stk.size() == 0) ? '0 : m_stk[m_stk.size()-1];
    endfunction

    task automatic m_update(input bit rst, input bit clr, input bit psh, input bit pop,
                            input logic [WIDTH-1:0] d);
        if (rst || clr) begin
            m_stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (psh && pop) begin
            if (m_stk.size() == 0) m_stk.push_back(d);
            else m_stk[m_stk.size()-1] = d;
        end else if (psh) begin
            if (m_stk.size() == DEPTH) m_ovf = 1'b1;
            else m_stk.push_back(d);
        end else if (pop) begin
            if (m_stk.size() == 0) m_unf = 1'b1;
            else void'(m_stk.pop_back());
        end
    endtask

    task automatic cyc(input bit rst, input bit clr, input bit psh, input bit pop,
                       input logic [WIDTH-1:0] d);
        reset  = rst;
        clear  = clr;
        pushEn = psh;
        popEn  = pop;
        dataIn = d;
        @(posedge clk);
        m_update(rst, clr, psh, pop, d);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, d);
    endtask

    task automatic pop();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, '0);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    endtask

    // Every cycle: all outputs against the queue model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_out",   32'(stackOut),   32'(m_top()));
            chk("model_count", 32'(count),      32'(m_stk.size()));
            chk("model_full",  32'(stackFull),  32'(m_stk.size() == DEPTH));
            chk("model_empty", 32'(stackEmpty), 32'(m_stk.size() == 0));
            chk("model_ovf",   32'(overflow),   32'(m_ovf));
            chk("model_unf",   32'(underflow),  32'(m_unf));
        end
    end

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        chk_en = 1'b0;
        reset = 1'b1; clear = 1'b0; pushEn = 1'b0; popEn = 1'b0; dataIn = '0;

        do_reset();
        do_reset();
        chk_en = 1'b1;
        idle();
        chk("rst_empty", 32'(stackEmpty), 32'd1);
        chk("rst_full",  32'(stackFull),  32'd0);
        chk("rst_count", 32'(count),      32'd0);
        chk("rst_out",   32'(stackOut),   32'h0000);
        chk("rst_ovf",   32'(overflow),   32'd0);
        chk("rst_unf",   32'(underflow),  32'd0);

        push(16'hA001); push(16'hB002); push(16'hC003);
        chk("p3_count", 32'(count), 32'd3);
        chk("p3_out",   32'(stackOut), 32'hC003);
        popEn = 1'b1;
        #1;
        chk("pop_same_cycle_out", 32'(stackOut), 32'hC003);
        pop();
        chk("pop_after_out",   32'(stackOut), 32'hB002);
        chk("pop_after_count", 32'(count),    32'd2);

        do_reset();
        for (int i = 0; i < 16; i++) push(16'(i));
        push(16'hFFFF);
        chk("full_flag",  32'(stackFull), 32'd1);
        chk("full_count", 32'(count),     32'd16);
        chk("full_out",   32'(stackOut),  32'h000F);
        chk("full_ovf",   32'(overflow),  32'd1);
        pop();
        chk("full_pop_out",  32'(stackOut),  32'h000E);
        chk("full_pop_flag", 32'(stackFull), 32'd0);
        chk("full_pop_ovf",  32'(overflow),  32'd1);

        do_reset();
        pop();
        chk("unf_count", 32'(count),     32'd0);
        chk("unf_out",   32'(stackOut),  32'h0000);
        chk("unf_flag",  32'(underflow), 32'd1);
        push(16'h1234);
        chk("unf_push_out",  32'(stackOut),  32'h1234);
        chk("unf_push_flag", 32'(underflow), 32'd1);

        do_reset();
        push(16'h1111); push(16'h5555);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h7777);
        chk("repl_count", 32'(count),    32'd2);
        chk("repl_out",   32'(stackOut), 32'h7777);
        pop();
        chk("repl_pop_out", 32'(stackOut), 32'h1111);

        do_reset();
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h2222);
        chk("both_empty_count", 32'(count),     32'd1);
        chk("both_empty_out",   32'(stackOut),  32'h2222);
        chk("both_empty_unf",   32'(underflow), 32'd0);

        do_reset();
        for (int i = 0; i < 17; i++) push(16'h3000 + 16'(i));
        for (int i = 0; i < 11; i++) pop();
        chk("pre_clr_count", 32'(count),    32'd5);
        chk("pre_clr_ovf",   32'(overflow), 32'd1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'hABCD);
        chk("clr_count", 32'(count),      32'd0);
        chk("clr_empty", 32'(stackEmpty), 32'd1);
        chk("clr_ovf",   32'(overflow),   32'd0);
        push(16'h4444);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h5678);
        chk("rst_push_count", 32'(count), 32'd0);

        // Randomized traffic in phases biased toward filling and draining.
        for (int ph = 0; ph < 12; ph++) begin
            int push_pct;
            push_pct = (ph % 3 == 0) ? 85 : ((ph % 3 == 1) ? 15 : 50);
            for (int n = 0; n < 150; n++) begin
                bit r_rst, r_clr, r_psh, r_pop;
                r_rst = ($urandom_range(0, 199) == 0);
                r_clr = ($urandom_range(0, 149) == 0);
                r_psh = ($urandom_range(0, 99) < push_pct);
                r_pop = ($urandom_range(0, 99) < (100 - push_pct));
                cyc(r_rst, r_clr, r_psh, r_pop, 16'($urandom));
            end
        end

        idle();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
